// File: rtl/bist_fault_campaign_ctrl.sv
// bist_fault_campaign_ctrl: exhaustive-pattern BIST sequencer with single stuck-at fault
// injection, golden-response capture and per-fault detection reporting.
`default_nettype none

module bist_fault_campaign_ctrl #(
  parameter int N_IN    = 3,
  parameter int N_SITES = 12,
  parameter int CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_IN-1:0]          cut_a,
  output logic [N_SITES-1:0]       cut_check,
  output logic                     cut_value,
  input  logic                     cut_y,
  output logic                     busy,
  output logic                     done,
  output logic [2**N_IN-1:0]       golden,
  output logic [2*N_SITES-1:0]     detected_mask,
  output logic [CNT_W-1:0]         fault_count
);

  localparam int NPAT   = 2**N_IN;
  localparam int NF     = 2*N_SITES;
  localparam int FIDX_W = $clog2(NF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GOLDEN = 2'd1,
    S_FAULT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     pat_q, pat_d;
  logic [FIDX_W-1:0]   fidx_q, fidx_d;
  logic                flag_q, flag_d;
  logic [NPAT-1:0]     golden_q, golden_d;
  logic [NF-1:0]       mask_q, mask_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [N_SITES-1:0]  check_q, check_d;
  logic                value_q, value_d;

  logic mismatch;
  logic hit;
  logic last_pat;

  assign mismatch = cut_y ^ golden_q[pat_q];
  assign hit      = flag_q | mismatch;
  assign last_pat = (pat_q == N_IN'(NPAT-1));

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    fidx_d   = fidx_q;
    flag_d   = flag_q;
    golden_d = golden_q;
    mask_d   = mask_q;
    count_d  = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_GOLDEN;
          pat_d    = '0;
          fidx_d   = '0;
          flag_d   = 1'b0;
          golden_d = '0;
          mask_d   = '0;
          count_d  = '0;
        end
      end
      S_GOLDEN: begin
        golden_d[pat_q] = cut_y;
        pat_d           = pat_q + N_IN'(1);
        if (last_pat) begin
          state_d = S_FAULT;
          fidx_d  = '0;
        end
      end
      S_FAULT: begin
        pat_d  = pat_q + N_IN'(1);
        flag_d = hit;
        // Every fault sees all patterns; the verdict is committed on the last one.
        if (last_pat) begin
          mask_d[fidx_q] = hit;
          count_d        = count_q + CNT_W'(hit);
          flag_d         = 1'b0;
          if (fidx_q == FIDX_W'(NF-1)) begin
            state_d = S_DONE;
            fidx_d  = '0;
          end else begin
            fidx_d = fidx_q + FIDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Fault-select drives are registered alongside the state that uses them.
    check_d = '0;
    value_d = 1'b0;
    if (state_d == S_FAULT) begin
      check_d = N_SITES'(1) << (fidx_d >> 1);
      value_d = fidx_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      fidx_q   <= '0;
      flag_q   <= 1'b0;
      golden_q <= '0;
      mask_q   <= '0;
      count_q  <= '0;
      check_q  <= '0;
      value_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      fidx_q   <= fidx_d;
      flag_q   <= flag_d;
      golden_q <= golden_d;
      mask_q   <= mask_d;
      count_q  <= count_d;
      check_q  <= check_d;
      value_q  <= value_d;
    end
  end

  assign cut_a         = pat_q;
  assign cut_check     = check_q;
  assign cut_value     = value_q;
  assign busy          = (state_q == S_GOLDEN) || (state_q == S_FAULT);
  assign done          = (state_q == S_DONE);
  assign golden        = golden_q;
  assign detected_mask = mask_q;
  assign fault_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_fault_campaign_ctrl.sv
// Bench for bist_fault_campaign_ctrl: a fault-injectable CUT model (y=b&c) plus stub CUTs,
// table-driven campaign results and hand-written reset / held-start / ignored-start sequences.
`default_nettype none

module tb_bist_fault_campaign_ctrl;

  localparam int N_IN    = 3;
  localparam int N_SITES = 12;
  localparam int CNT_W   = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic [N_IN-1:0]        cut_a;
  logic [N_SITES-1:0]     cut_check;
  logic                   cut_value;
  logic                   cut_y;
  logic                   busy;
  logic                   done;
  logic [7:0]             golden;
  logic [23:0]            detected_mask;
  logic [CNT_W-1:0]       fault_count;

  int tests = 0;
  int fails = 0;
  int mode  = 0;

  always #5 clk = ~clk;

  bist_fault_campaign_ctrl #(.N_IN(N_IN), .N_SITES(N_SITES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cut_a(cut_a), .cut_check(cut_check), .cut_value(cut_value), .cut_y(cut_y),
    .busy(busy), .done(done), .golden(golden),
    .detected_mask(detected_mask), .fault_count(fault_count)
  );

  // Real CUT: a=a[0], b=a[1], c=a[2]. Sites 0,3,4,5,8 form an a-chain feeding only a
  // tautology; site 10 (b|c) is redundant for stuck-at-1.
  function automatic logic fs(input logic chk, input logic val, input logic nom);
    return chk ? val : nom;
  endfunction

  logic n_a, n_a3, n_a4, n_a5, n_a8, n_b, n_c, n_t, n_t1, n_t2, n_u, y_real;
  always_comb begin
    n_a    = fs(cut_check[0],  cut_value, cut_a[0]);
    n_a3   = fs(cut_check[3],  cut_value, n_a);
    n_a4   = fs(cut_check[4],  cut_value, n_a3);
    n_a5   = fs(cut_check[5],  cut_value, n_a4);
    n_a8   = fs(cut_check[8],  cut_value, n_a5);
    n_b    = fs(cut_check[1],  cut_value, cut_a[1]);
    n_c    = fs(cut_check[2],  cut_value, cut_a[2]);
    n_t    = fs(cut_check[6],  cut_value, n_b & n_c);
    n_t1   = fs(cut_check[7],  cut_value, n_t);
    n_t2   = fs(cut_check[9],  cut_value, n_t1);
    n_u    = fs(cut_check[10], cut_value, n_b | n_c);
    y_real = fs(cut_check[11], cut_value, n_t2 & n_u & (n_a8 | ~n_a8));
  end

  always_comb begin
    case (mode)
      0:       cut_y = y_real;
      1:       cut_y = 1'b0;
      2:       cut_y = cut_check[3] & cut_value;
      3:       cut_y = cut_a[0];
      4:       cut_y = cut_check[11] & cut_value;
      5:       cut_y = cut_check[0] ? cut_value : cut_a[2];
      default: cut_y = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " cut_a"},     32'(cut_a), 32'h0);
    check({tag, " cut_check"}, 32'(cut_check), 32'h0);
    check({tag, " cut_value"}, 32'(cut_value), 32'h0);
    check({tag, " busy"},      32'(busy), 32'h0);
    check({tag, " done"},      32'(done), 32'h0);
    check({tag, " golden"},    32'(golden), 32'h0);
    check({tag, " mask"},      32'(detected_mask), 32'h0);
    check({tag, " count"},     32'(fault_count), 32'h0);
  endtask

  // One start pulse, then watch every cycle until done; optionally pulse start mid-run and in DONE.
  task automatic run_campaign(input logic noise, output int lat, output int mon_err);
    int edges;
    int fidx;
    logic [N_SITES-1:0] exp_chk;
    logic exp_v;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    edges   = 0;
    lat     = -1;
    mon_err = 0;
    while (edges <= 250) begin
      @(negedge clk);
      if (done) begin
        lat = edges;
        break;
      end
      if (edges < 8) begin
        exp_chk = '0;
        exp_v   = 1'b0;
      end else begin
        fidx    = (edges - 8) / 8;
        exp_chk = N_SITES'(1) << (fidx / 2);
        exp_v   = 1'(fidx % 2);
      end
      if (!busy) mon_err++;
      if (cut_a !== N_IN'(edges % 8) || cut_check !== exp_chk || cut_value !== exp_v) mon_err++;
      if (edges >= 8 && $countones(cut_check) != 1) mon_err++;
      start = noise && (edges == 3 || edges == 120 || edges == 199);
      @(posedge clk);
      edges++;
    end
    if (lat >= 0) begin
      check("done busy", 32'(busy), 32'h0);
      check("done cut_check", 32'(cut_check), 32'h0);
      check("done cut_a/value", {28'h0, cut_a, cut_value}, 32'h0);
      start = noise;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("post-done done", 32'(done), 32'h0);
      check("post-done busy", 32'(busy), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("idle busy", 32'(busy), 32'h0);
    end
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic        noise;
    logic [7:0]  g;
    logic [23:0] m;
    logic [4:0]  c;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, mon_err;
    int dn[4];
    int ndone;

    vecs[0] = '{"real",        0, 1'b0, 8'hC0, 24'hDCF03C, 5'd13};
    vecs[1] = '{"stub0",       1, 1'b0, 8'h00, 24'h000000, 5'd0};
    vecs[2] = '{"site3sa1",    2, 1'b0, 8'h00, 24'h000080, 5'd1};
    vecs[3] = '{"y=a0",        3, 1'b0, 8'hAA, 24'h000000, 5'd0};
    vecs[4] = '{"site11sa1",   4, 1'b0, 8'h00, 24'h800000, 5'd1};
    vecs[5] = '{"site0both",   5, 1'b0, 8'hF0, 24'h000003, 5'd2};
    vecs[6] = '{"real+noise",  0, 1'b1, 8'hC0, 24'hDCF03C, 5'd13};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].mode;
      run_campaign(vecs[i].noise, lat, mon_err);
      check({vecs[i].name, " latency"}, 32'(lat), 32'd200);
      check({vecs[i].name, " monitor"}, 32'(mon_err), 32'd0);
      repeat (3) @(negedge clk);
      check({vecs[i].name, " golden"}, 32'(golden), 32'(vecs[i].g));
      check({vecs[i].name, " mask"},   32'(detected_mask), 32'(vecs[i].m));
      check({vecs[i].name, " count"},  32'(fault_count), 32'(vecs[i].c));
    end

    // Asynchronous reset in the middle of the fault phase, then a clean rerun.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset");
    rst_n = 1'b1;
    run_campaign(1'b0, lat, mon_err);
    check("rerun latency", 32'(lat), 32'd200);
    check("rerun monitor", 32'(mon_err), 32'd0);
    check("rerun mask",    32'(detected_mask), 32'hDCF03C);
    check("rerun count",   32'(fault_count), 32'd13);

    // start held high: each new campaign only begins after DONE has returned to IDLE.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int e = 0; e < 410; e++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 4) dn[ndone] = e;
        ndone++;
        check("held done mask",  32'(detected_mask), 32'hDCF03C);
        check("held done count", 32'(fault_count), 32'd13);
      end
      if (e == 201) check("held idle busy", 32'(busy), 32'h0);
      if (e == 202) check("held restart busy", 32'(busy), 32'h1);
      @(posedge clk);
    end
    check("held done count", 32'(ndone), 32'd2);
    if (ndone >= 2) begin
      check("held first done",  32'(dn[0]), 32'd200);
      check("held second done", 32'(dn[1]), 32'd402);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_zero("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
